// File: rtl/dnn_pkg.sv
// Shared DNN constants and FSM types for the output layer and the argmax stage after it.
package dnn_pkg;
  localparam int OUT_LAYER_WIDTH = 17;
  localparam int NUM_CLASSES     = 4;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;
endpackage

// File: rtl/argmax_cmp.sv
// Signed strict greater-than. A tie keeps the incumbent, so the lower class index wins.
module argmax_cmp #(
  parameter int W = 17
) (
  input  logic signed [W-1:0] i_cand,
  input  logic signed [W-1:0] i_max,
  output logic                o_take_new
);
  assign o_take_new = (i_cand > i_max);
endmodule

// File: rtl/output_argmax.sv
// Running argmax over NUM_CLASSES streamed scores.
// The winner is presented on a valid/ready port. A score that arrives while the port is held is dropped and flagged.
module output_argmax
  import dnn_pkg::*;
#(
  parameter  int DATA_WIDTH  = dnn_pkg::OUT_LAYER_WIDTH,
  parameter  int NUM_CLASSES = dnn_pkg::NUM_CLASSES,
  localparam int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [IDX_WIDTH-1:0]  out_class,
  output logic signed [DATA_WIDTH-1:0] out_score,
  output logic                         overrun
);

  state_e                        r_state, w_state_nxt;
  logic        [IDX_WIDTH-1:0]   r_count, r_max_idx, r_out_class;
  logic signed [DATA_WIDTH-1:0]  r_max_score, r_out_score;
  logic                          r_overrun;

  logic                          w_acc, w_last, w_take_new, w_take;
  logic signed [DATA_WIDTH-1:0]  w_new_max;
  logic        [IDX_WIDTH-1:0]   w_new_idx;

  argmax_cmp #(.W(DATA_WIDTH)) u_cmp (
    .i_cand     (in_data),
    .i_max      (r_max_score),
    .o_take_new (w_take_new)
  );

  // Flush suppresses acceptance, so a sample in a flush cycle is not counted.
  assign w_acc     = in_valid && (r_state == ACCUM) && !flush;
  assign w_last    = w_acc && (r_count == IDX_WIDTH'(NUM_CLASSES - 1));
  assign w_take    = (r_count == '0) || w_take_new;
  assign w_new_max = w_take ? in_data : r_max_score;
  assign w_new_idx = w_take ? r_count : r_max_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_last)    w_state_nxt = HOLD;
        HOLD:    if (out_ready) w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == ACCUM);
    out_valid = (r_state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_max_score <= '0;
      r_max_idx   <= '0;
      r_out_score <= '0;
      r_out_class <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_acc) begin
      r_max_score <= w_new_max;
      r_max_idx   <= w_new_idx;
      if (w_last) begin
        r_count     <= '0;
        r_out_score <= w_new_max;
        r_out_class <= w_new_idx;
      end else begin
        r_count <= r_count + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_overrun <= 1'b0;
    else if (flush)                           r_overrun <= 1'b0;
    else if (in_valid && (r_state == HOLD))   r_overrun <= 1'b1;
  end

  assign out_class = r_out_class;
  assign out_score = r_out_score;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax. Inputs are driven and outputs are sampled on the falling edge.
module tb_output_argmax;
  localparam int DW = 17;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid, flush, out_ready;
  logic signed [DW-1:0] in_data;
  logic                 in_ready, out_valid, overrun;
  logic        [IW-1:0] out_class;
  logic signed [DW-1:0] out_score;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  output_argmax dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = DW'(v);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic frame(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic chk_res(input string tag, input int cls, input int sc);
    chk({tag, ".vld"},   int'(out_valid), 1);
    chk({tag, ".class"}, int'(out_class), cls);
    chk({tag, ".score"}, int'(out_score), sc);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.vld", int'(out_valid), 0);
    chk("rst.rdy", int'(in_ready), 1);
    chk("rst.class", int'(out_class), 0);
    chk("rst.score", int'(out_score), 0);
    chk("rst.ovr", int'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: max at index 2, one-cycle pulse with out_ready held high.
    frame(5, -3, 12, 7);
    chk_res("t1", 2, 12);
    chk("t1.rdy_hold", int'(in_ready), 0);
    @(negedge clk);
    chk("t1.pulse", int'(out_valid), 0);
    chk("t1.rdy", int'(in_ready), 1);

    // A tie keeps the lower index.
    frame(-100, -100, -200, -150);
    chk_res("t2", 0, -100);
    @(negedge clk);

    // Most negative score is a legal value.
    frame(-65536, -65536, -65536, -65535);
    chk_res("t3", 3, -65535);
    @(negedge clk);

    // Back-pressure: hold for 5 cycles and drop a score in the second cycle.
    out_ready = 1'b0;
    frame(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      in_data  = DW'(100);
      @(negedge clk);
      chk_res("t4.hold", 3, 4);
    end
    in_valid = 1'b0;
    chk("t4.ovr", int'(overrun), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4.rel", int'(out_valid), 0);
    frame(-1, -2, -3, -4);
    chk_res("t4.next", 0, -1);
    chk("t4.ovr_sticky", int'(overrun), 1);
    @(negedge clk);

    // Flush mid-frame: it clears overrun and the partial frame produces nothing.
    send(50); send(60);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5.ovr", int'(overrun), 0);
    chk("t5.novld", int'(out_valid), 0);
    send(10); send(20);
    chk("t5.noabort", int'(out_valid), 0);
    send(30); send(40);
    chk_res("t5", 3, 40);
    chk("t5.ovr2", int'(overrun), 0);
    @(negedge clk);

    // Flush in the same cycle as the last sample wins over completion.
    send(1); send(2); send(3);
    flush = 1'b1;
    send(99);
    flush = 1'b0;
    chk("t5b.novld", int'(out_valid), 0);
    frame(7, 3, 2, 1);
    chk_res("t5b", 0, 7);
    @(negedge clk);

    // Async reset during the third score of a frame.
    send(30); send(40);
    in_valid = 1'b1; in_data = DW'(50);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst.vld", int'(out_valid), 0);
    chk("t6.rst.class", int'(out_class), 0);
    chk("t6.rst.score", int'(out_score), 0);
    chk("t6.rst.ovr", int'(overrun), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    frame(9, 1, 1, 1);
    chk_res("t6", 0, 9);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Classifier stage directly downstream of the output-layer neurons.
- Consumes a stream of signed class scores, one per valid cycle, from a time-multiplexed output neuron, and tracks the running maximum.
- After NUM_CLASSES scores it presents the winning class index and score on a valid/ready output port.
- Detects and flags scores that arrive while the block cannot accept them; the upstream neuron has no stall capability.

Parameters:
- DATA_WIDTH, 17, width of a signed class score (output-layer neuron result width).
- NUM_CLASSES, 4, scores per frame; legal range 2..16.
- IDX_WIDTH, $clog2(NUM_CLASSES), derived localparam, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  score valid; driven by the neuron's result_ready.
- in_data  input  DATA_WIDTH  signed score; driven by the neuron's result.
- in_ready  output  1  high when a score can be accepted.
- flush  input  1  synchronous frame abort.
- out_valid  output  1  class result valid.
- out_ready  input  1  consumer accepts the result.
- out_class  output  IDX_WIDTH  index of the maximum score, 0-based arrival order.
- out_score  output  DATA_WIDTH  signed maximum score.
- overrun  output  1  sticky flag: a score was dropped.

Behaviour:
- Reset values (async, rst_n low): state=ACCUM, count=0, max_score=0, max_idx=0, out_valid=0, out_class=0, out_score=0, overrun=0.
- in_ready is a combinational decode of state: 1 in ACCUM, 0 in HOLD. It does not depend on in_valid.
- FSM states:
  - ACCUM: a sample is accepted on any cycle with in_valid=1.
  - HOLD: a result is being presented.
- Accept in ACCUM:
  - count==0: load max_score=in_data, max_idx=0 unconditionally.
  - count>0: update max_score/max_idx only if in_data > max_score (signed compare). Ties keep the lower index.
  - count increments per accepted sample.
- Frame completion:
  - On the cycle the sample with count==NUM_CLASSES-1 is accepted, the final max (including that sample) is registered into out_score/out_class.
  - Next cycle: out_valid=1, state=HOLD, count=0.
  - Latency: out_valid rises exactly 1 cycle after the last score is accepted.
- HOLD:
  - out_valid, out_class and out_score stay stable until the cycle where out_valid and out_ready are both high.
  - Next cycle after that handshake: out_valid=0, state=ACCUM.
  - There is no same-cycle restart; HOLD always lasts at least 1 cycle.
- Overrun: in_valid=1 while in_ready=0 (HOLD) sets overrun=1 next cycle. The sample is discarded and max/count are unaffected. overrun stays set until flush or reset.
- flush=1 takes priority over every other event in the same cycle:
  - next cycle: count=0, state=ACCUM, out_valid=0, overrun=0.
  - Any concurrent in_valid sample or out handshake is ignored.
  - out_class/out_score keep their old values; they are don't-care while out_valid=0.
- Arithmetic: compare only, no addition, so no overflow. Full signed range is supported; -2^(DATA_WIDTH-1) is a legal score.
- Mid-frame reset: async clear to reset values; the partial frame is lost.
- Simultaneous last sample and flush: flush wins; no result is produced.
- in_data is sampled only on accepted cycles; X on in_data while in_valid=0 must not propagate.

Decomposition:
- Shared package dnn_pkg:
  - typedef state_e {ACCUM, HOLD}.
  - Constants OUT_LAYER_WIDTH=17 and NUM_CLASSES=4, also used by the output-layer instantiation.
- One natural sub-module, argmax_cmp: combinational signed compare, strict greater-than, producing take_new.

Test Plan:
- Scores 5, -3, 12, 7 on consecutive cycles, out_ready=1 → out_valid 1 cycle after the 4th score; out_class=2, out_score=12; single-cycle pulse.
- Scores -100, -100, -200, -150 (tie) → out_class=0, out_score=-100.
- Scores -65536, -65536, -65536, -65535 (min value) → out_class=3, out_score=-65535.
- Frame 1, 2, 3, 4 then out_ready=0 for 5 cycles with in_valid pulsed in cycle 2 → out_valid held, out_class=3 stable; overrun=1; second frame's max/count unaffected after release.
- 2 scores, then flush, then 10, 20, 30, 40 → out_class=3, out_score=40, overrun=0; no result from the aborted frame.
- rst_n low during 3rd score of a frame, then a full frame 9, 1, 1, 1 → all outputs 0 during reset; result out_class=0, out_score=9.
